// File: rtl/ibex_ram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter in the Ibex demo system.
// Host indices, response record and default RAM window base.
package ibex_ram_arb_pkg;

    localparam int          NumHosts    = 3;
    localparam int          HostInstr   = 0;
    localparam int          HostData    = 1;
    localparam int          HostDbg     = 2;
    localparam logic [31:0] RamAddrBase = 32'h0010_0000;

    // Wide enough for up to 16 hosts so the record stays fixed-size.
    localparam int          RespIdxW    = 4;

    typedef struct packed {
        logic                valid;
        logic [RespIdxW-1:0] idx;
        logic                err;
        logic                we;
    } resp_t;

endpackage

// File: rtl/ibex_rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr, wrapping.
// Returns one-hot grant, binary winner index and an any-grant flag.
module ibex_rr_arbiter #(
    parameter int NumReq = 3,
    parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [NumReq-1:0] gnt,
    output logic [IdxW-1:0]   idx,
    output logic              valid
);

    always_comb begin
        int c;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        for (int i = 0; i < NumReq; i++) begin
            c = int'(ptr) + i;
            if (c >= NumReq) c = c - NumReq;
            if (!valid && req[c]) begin
                valid  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IdxW'(c);
            end
        end
    end

endmodule

// File: rtl/ibex_ram_arbiter.sv
// Shares the single-port SRAM between instr, data and debug hosts with
// round-robin grants, window decode and a fixed 1-cycle response path.
module ibex_ram_arbiter
    import ibex_ram_arb_pkg::*;
#(
    parameter int          NumReq       = NumHosts,
    parameter int          MemSizeBytes = 65536,
    parameter logic [31:0] AddrBase     = RamAddrBase,
    parameter int          MemAw        = $clog2(MemSizeBytes / 4)
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_sys_ni,
    input  logic [NumReq-1:0]        host_req_i,
    input  logic [NumReq-1:0]        host_we_i,
    input  logic [NumReq-1:0][3:0]   host_be_i,
    input  logic [NumReq-1:0][31:0]  host_addr_i,
    input  logic [NumReq-1:0][31:0]  host_wdata_i,
    output logic [NumReq-1:0]        host_gnt_o,
    output logic [NumReq-1:0]        host_rvalid_o,
    output logic [NumReq-1:0][31:0]  host_rdata_o,
    output logic [NumReq-1:0]        host_err_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [3:0]               mem_be_o,
    output logic [MemAw-1:0]         mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    input  logic [31:0]              mem_rdata_i
);

    localparam int          IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [31:0] WinMask = ~(32'(MemSizeBytes) - 32'd1);

    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] win_idx;
    logic            any_gnt;
    logic [31:0]     win_addr;
    logic            in_win;
    resp_t           resp_q;
    logic [31:0]     rdata;

    ibex_rr_arbiter #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_arbiter (
        .req   (host_req_i),
        .ptr   (rr_ptr),
        .gnt   (host_gnt_o),
        .idx   (win_idx),
        .valid (any_gnt)
    );

    assign win_addr = host_addr_i[win_idx];
    assign in_win   = (win_addr & WinMask) == AddrBase;

    // Payload is zeroed when idle so the SRAM pins stay quiet.
    assign mem_req_o   = any_gnt & in_win;
    assign mem_we_o    = any_gnt & host_we_i[win_idx];
    assign mem_be_o    = any_gnt ? host_be_i[win_idx]    : 4'h0;
    assign mem_wdata_o = any_gnt ? host_wdata_i[win_idx] : 32'h0;
    assign mem_addr_o  = any_gnt ? win_addr[MemAw+1:2]   : '0;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            rr_ptr <= '0;
            resp_q <= '0;
        end else begin
            if (any_gnt) begin
                rr_ptr <= (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + 1'b1;
            end
            resp_q.valid <= any_gnt;
            resp_q.idx   <= RespIdxW'(win_idx);
            resp_q.err   <= any_gnt & ~in_win;
            resp_q.we    <= any_gnt & host_we_i[win_idx];
        end
    end

    // Read data only passes through for a good read; writes and errors return 0.
    assign rdata         = (resp_q.valid && !resp_q.err && !resp_q.we) ? mem_rdata_i : 32'h0;
    assign host_rdata_o  = {NumReq{rdata}};
    assign host_rvalid_o = resp_q.valid ? (NumReq'(1) << resp_q.idx) : '0;
    assign host_err_o    = (resp_q.valid && resp_q.err) ? (NumReq'(1) << resp_q.idx) : '0;

endmodule

// File: doc/ibex_ram_arbiter.md
# ibex_ram_arbiter

Round-robin arbiter that shares the demo system's single-port on-chip SRAM between several Ibex-protocol hosts: core instruction fetch, core data, and the debug module's system bus access. It sits between the hosts and the SRAM. It grants one request per cycle, decodes the RAM address window, and routes the fixed 1-cycle SRAM response back to the granted host. Accesses outside the window complete with an error response.

## Interface
- NumReq, 3, number of hosts; index 0 = instr, 1 = data, 2 = debug
- MemSizeBytes, 65536, SRAM size in bytes; power of two
- AddrBase, 32'h0010_0000, byte base address of the RAM window; aligned to MemSizeBytes
- MemAw, derived $clog2(MemSizeBytes/4), SRAM word-address width

- clk_sys_i  in  1  system clock
- rst_sys_ni  in  1  reset, asynchronous, active-low
- host_req_i  in  NumReq  request per host
- host_we_i  in  NumReq  write enable per host
- host_be_i  in  NumReq×4  byte enables per host
- host_addr_i  in  NumReq×32  byte address per host
- host_wdata_i  in  NumReq×32  write data per host
- host_gnt_o  out  NumReq  grant, one-hot or zero
- host_rvalid_o  out  NumReq  response valid, one-hot or zero
- host_rdata_o  out  NumReq×32  read data, same value broadcast to all hosts
- host_err_o  out  NumReq  error, qualified by host_rvalid_o
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  MemAw  SRAM word address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid 1 cycle after mem_req_o

## Operation
- State registers:
  - rr_ptr, range 0..NumReq-1, reset 0
  - resp_valid, resp_idx, resp_err, resp_we, reset 0
- Arbitration:
  - Winner is the first asserted host_req_i searching upward from rr_ptr, wrapping at NumReq.
  - host_gnt_o[winner]=1 in the same cycle.
  - On any grant, rr_ptr <= (winner+1) mod NumReq.
  - With no request, rr_ptr holds.
- In-window access: (addr & ~(MemSizeBytes-1)) == AddrBase.
  - mem_req_o=1.
  - mem_we/be/wdata come from the winner.
  - mem_addr_o = addr[MemAw+1:2]; addr[1:0] is ignored.
- Out-of-window access:
  - The grant is still given; mem_req_o=0.
  - resp_err is set for the response.
- Response, the cycle after a grant:
  - host_rvalid_o[resp_idx]=1. This applies to writes too.
  - host_err_o[resp_idx]=resp_err.
  - host_rdata_o = mem_rdata_i for an in-window read; 0 for writes and errors.
- Back-to-back grants every cycle are legal, so up to one response is in flight.
- Hosts hold req and payload stable until gnt; the arbiter does not buffer requests.
- Reset asserted mid-operation:
  - The in-flight response is discarded; no rvalid appears after reset release.
  - rr_ptr returns to 0.

## Timing
- Reset values of outputs:
  - host_gnt_o and mem_* follow combinationally from host_req_i, which gives 0 when no request is present.
  - host_rvalid_o=0, host_err_o=0, host_rdata_o=0.
- host_req_i to host_gnt_o and mem_req_o is a combinational path, with zero-cycle grant latency.
- host_gnt_o to host_rvalid_o is exactly 1 cycle, with no variability.
- All hosts requesting continuously: each host is granted once every NumReq cycles. Worst-case wait is NumReq-1 cycles.
- A single host requesting continuously is granted every cycle.

## Structure
- Package ibex_ram_arb_pkg holds:
  - host index constants: HostInstr=0, HostData=1, HostDbg=2
  - the response struct (valid, idx, err, we)
  - the default AddrBase
- Sub-module ibex_rr_arbiter takes req vector and pointer and returns a one-hot grant and binary winner index. It is purely combinational and reusable for the peripheral bus.
- Top level holds rr_ptr, the address decode, the payload mux and the response register.

## Test plan
- Single data write then read: host1 writes 0xDEADBEEF to 0x0010_0010 with be=0xF.
  - mem_addr_o=4; gnt the same cycle; rvalid[1] the next cycle.
  - The read returns 0xDEADBEEF with err=0.
- All three hosts request continuously for 9 cycles from reset: grant order is 0,1,2,0,1,2,0,1,2 and each host gets 3 rvalids.
- Out-of-window: host2 reads 0x0000_1000.
  - gnt[2]=1 and mem_req_o=0.
  - Next cycle: rvalid[2]=1, err[2]=1, rdata=0.
- Byte write: host1 writes 0x000000AB with be=0x1 over a word holding 0x11223344, then reads it back.
  - The read returns 0x112233AB.
- Reset mid-flight: assert rst_sys_ni low on the cycle after a host0 grant.
  - No rvalid is seen after release.
  - The first post-reset grant with all hosts requesting goes to host0.
- Fairness: host0 requests every cycle and host1 raises req at cycle 5.
  - host1 is granted at cycle 5 or 6; host0 is never granted twice in a row while host1 waits.
